reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader_if.sv | 19 +
 rtl/reg_dump_reader.sv | 180 ++++++++++++++++++
 tb/tb_reg_dump_reader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_if.sv
// Byte stream from the register dump reader to a serial transmitter.
// Master drives data/valid, slave returns ready.
interface reg_dump_reader_if;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready
    );

    modport slave (
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Streams every register-file word out as bytes, MSB first, while the core is halted.
// Define REG_DUMP_FRAME_EN to wrap the dump in an 0xA5 header and an XOR checksum byte.
module reg_dump_reader #(
    parameter int DWIDTH = 32,
    parameter int MDEPTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              i_start,
    input  logic              i_dbg_run,
    output logic [AWIDTH-1:0] o_ra,
    input  logic [DWIDTH-1:0] i_rd,
    reg_dump_reader_if.master tx,
    output logic              o_busy,
    output logic              o_done
);

`ifdef REG_DUMP_FRAME_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, SEND, DONE, HDR, CSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, FETCH, SEND, DONE
    } state_t;
`endif

    state_t            state;
    state_t            nxt;
    logic [DWIDTH-1:0] shbuf;
    logic [1:0]        bcnt;
    logic [AWIDTH:0]   idx;
    logic              abort;
    logic              last_reg;
    logic              stop;
    logic              tx_vld;
    logic [7:0]        tx_data;
`ifdef REG_DUMP_FRAME_EN
    logic [7:0]        csum;
`endif

    assign last_reg = (idx == (AWIDTH+1)'(MDEPTH - 1));
    // A run request seen earlier in the byte still ends the dump after it
    assign stop     = abort | i_dbg_run;
    assign o_ra     = idx[AWIDTH-1:0];
    assign o_done   = (state == DONE);

`ifdef REG_DUMP_FRAME_EN
    assign tx_vld = (state == SEND) | (state == HDR) | (state == CSUM);
`else
    assign tx_vld = (state == SEND);
`endif
    assign o_busy = tx_vld | (state == FETCH);

    assign tx.o_tx_valid = tx_vld;
    assign tx.o_tx_data  = tx_data;

    always_comb begin
        tx_data = 8'h00;
        unique case (state)
            SEND:    tx_data = shbuf[DWIDTH-1 -: 8];
`ifdef REG_DUMP_FRAME_EN
            HDR:     tx_data = 8'hA5;
            CSUM:    tx_data = csum;
`endif
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (i_start && !i_dbg_run) begin
`ifdef REG_DUMP_FRAME_EN
                    nxt = HDR;
`else
                    nxt = FETCH;
`endif
                end
            end
            FETCH: begin
                nxt = i_dbg_run ? IDLE : SEND;
            end
            SEND: begin
                if (tx.i_tx_ready) begin
                    if (stop) begin
                        nxt = IDLE;
                    end else if (bcnt == 2'd3) begin
`ifdef REG_DUMP_FRAME_EN
                        nxt = last_reg ? CSUM : FETCH;
`else
                        nxt = last_reg ? DONE : FETCH;
`endif
                    end
                end
            end
`ifdef REG_DUMP_FRAME_EN
            HDR: begin
                if (tx.i_tx_ready) begin
                    nxt = stop ? IDLE : FETCH;
                end
            end
            CSUM: begin
                if (tx.i_tx_ready) begin
                    nxt = stop ? IDLE : DONE;
                end
            end
`endif
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            shbuf <= '0;
            bcnt  <= 2'd0;
            idx   <= '0;
            abort <= 1'b0;
`ifdef REG_DUMP_FRAME_EN
            csum  <= 8'h00;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    bcnt  <= 2'd0;
                    idx   <= '0;
                    abort <= 1'b0;
`ifdef REG_DUMP_FRAME_EN
                    csum  <= 8'h00;
`endif
                end
                FETCH: begin
                    shbuf <= i_rd;
                    bcnt  <= 2'd0;
                end
                SEND: begin
                    if (i_dbg_run) begin
                        abort <= 1'b1;
                    end
                    if (tx.i_tx_ready) begin
                        shbuf <= {shbuf[DWIDTH-9:0], 8'h00};
                        bcnt  <= bcnt + 2'd1;
`ifdef REG_DUMP_FRAME_EN
                        csum  <= csum ^ shbuf[DWIDTH-1 -: 8];
`endif
                        if (bcnt == 2'd3) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef REG_DUMP_FRAME_EN
                HDR, CSUM: begin
                    if (i_dbg_run) begin
                        abort <= 1'b1;
                    end
                end
`endif
                default: begin
                    abort <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a flat byte-stream model feeds a queue,
// a negedge monitor pops and compares every transferred byte.
module tb_reg_dump_reader;
    localparam int MDEPTH = 32;
    localparam int AWIDTH = 5;
`ifdef REG_DUMP_FRAME_EN
    localparam int FRAME = 1;
`else
    localparam int FRAME = 0;
`endif

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              i_start = 1'b0;
    logic              i_dbg_run = 1'b0;
    logic [AWIDTH-1:0] o_ra;
    logic [31:0]       i_rd;
    logic              o_busy;
    logic              o_done;
    logic [31:0]       rf [MDEPTH];

    reg_dump_reader_if tx ();

    reg_dump_reader #(.DWIDTH(32), .MDEPTH(MDEPTH), .AWIDTH(AWIDTH)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .i_start   (i_start),
        .i_dbg_run (i_dbg_run),
        .o_ra      (o_ra),
        .i_rd      (i_rd),
        .tx        (tx),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    assign i_rd = rf[o_ra];

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        int         ra;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   xfer_cnt = 0;
    int   rmode = 0;
    logic       hold = 1'b0;
    logic [7:0] hold_d = 8'h00;

    always @(posedge CLK) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Expected stream: optional header, the first nbytes of RF as MSB-first bytes,
    // and the XOR checksum only for a complete dump.
    task automatic push_dump(input int nbytes);
        logic [7:0] c;
        logic [7:0] bt;
        logic [31:0] w;
        c = 8'h00;
        if (FRAME != 0) q.push_back('{8'hA5, -1});
        for (int k = 0; k < nbytes; k++) begin
            w  = rf[k / 4];
            bt = 8'(w >> (8 * (3 - (k % 4))));
            c  = c ^ bt;
            q.push_back('{bt, k / 4});
        end
        if (FRAME != 0 && nbytes == 4 * MDEPTH) q.push_back('{c, -1});
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RSTn) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("held_valid", {31'd0, tx.o_tx_valid}, 32'd1);
                check("held_data", {24'd0, tx.o_tx_data}, {24'd0, hold_d});
            end
            hold   = tx.o_tx_valid && !tx.i_tx_ready;
            hold_d = tx.o_tx_data;
            if (tx.o_tx_valid && tx.i_tx_ready) begin
                xfer_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte actual=%0h required=none (cycle %0d)", tx.o_tx_data, cyc);
                end else begin
                    e = q.pop_front();
                    check("byte", {24'd0, tx.o_tx_data}, {24'd0, e.b});
                    if (e.ra >= 0) check("ra", {27'd0, o_ra}, e.ra);
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        tx.i_tx_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (rmode == 0) tx.i_tx_ready = 1'b1;
            else if (rmode == 1) tx.i_tx_ready = ~tx.i_tx_ready;
            else if (rmode == 2) tx.i_tx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic start_dump();
        @(posedge CLK); #1;
        i_start = 1'b1;
        @(posedge CLK); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check(nm, done_cnt, target);
        repeat (3) @(negedge CLK);
        check({nm, "_pulse"}, done_cnt, target);
        check({nm, "_qempty"}, q.size(), 0);
    endtask

    task automatic rand_rf();
        for (int i = 0; i < MDEPTH; i++) rf[i] = $urandom;
    endtask

    initial begin
        int st;
        int n;
        int seen;
        int x0;
        for (int i = 0; i < MDEPTH; i++) rf[i] = 32'(i) * 32'h01010101;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_valid", {31'd0, tx.o_tx_valid}, 0);
        check("rst_data", {24'd0, tx.o_tx_data}, 0);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_done", {31'd0, o_done}, 0);
        check("rst_ra", {27'd0, o_ra}, 0);
        @(posedge CLK); #1;
        RSTn = 1'b1;

        // Ramp pattern, ready held high: latency and total length
        rmode = 0;
        push_dump(4 * MDEPTH);
        x0 = xfer_cnt;
        @(posedge CLK); #1;
        i_start = 1'b1;
        st = cyc;
        @(posedge CLK); #1;
        i_start = 1'b0;
        @(negedge CLK);
        check("lat_n1_valid", {31'd0, tx.o_tx_valid}, FRAME);
        check("lat_n1_busy", {31'd0, o_busy}, 1);
        @(negedge CLK);
        check("lat_n2_valid", {31'd0, tx.o_tx_valid}, 1 - FRAME);
        check("lat_n2_ra", {27'd0, o_ra}, 0);
        wait_done(1, "ramp_done");
        check("ramp_done_cycle", done_cyc - st, 1 + 5 * MDEPTH + 2 * FRAME);
        check("ramp_xfers", xfer_cnt - x0, 4 * MDEPTH + 2 * FRAME);

        // Ready toggling every cycle
        rand_rf();
        rf[2] = 32'h00000F00;
        rmode = 1;
        push_dump(4 * MDEPTH);
        start_dump();
        wait_done(2, "toggle_done");

        // Random ready, with stray start pulses mid-dump
        for (int t = 0; t < 2; t++) begin
            rand_rf();
            rmode = 2;
            push_dump(4 * MDEPTH);
            start_dump();
            repeat (20) @(posedge CLK);
            #1 i_start = 1'b1;
            @(posedge CLK);
            #1 i_start = 1'b0;
            wait_done(3 + t, "rand_done");
        end

        // Start while core running is ignored
        rmode = 0;
        i_dbg_run = 1'b1;
        start_dump();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (o_busy || tx.o_tx_valid) seen++;
        end
        check("run_ignored", seen, 0);
        check("run_no_done", done_cnt, 4);
        i_dbg_run = 1'b0;

        // Run raised while byte 1 of register 5 is held
        rand_rf();
        rf[5] = 32'h11223344;
        rmode = 3;
        tx.i_tx_ready = 1'b1;
        push_dump(5 * 4 + 2);
        start_dump();
        n = 0;
        while (!(tx.o_tx_valid && o_ra == 5 && tx.o_tx_data == 8'h11) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL abort_reach actual=timeout required=reg5_byte0");
        end
        @(posedge CLK); #1;
        tx.i_tx_ready = 1'b0;
        i_dbg_run = 1'b1;
        repeat (3) @(posedge CLK);
        #1 tx.i_tx_ready = 1'b1;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        check("abort_idle", {31'd0, o_busy}, 0);
        check("abort_no_done", done_cnt, 4);
        check("abort_qempty", q.size(), 0);
        i_dbg_run = 1'b0;

        // Reset in the middle of a dump
        rmode = 0;
        rand_rf();
        push_dump(4 * MDEPTH);
        start_dump();
        repeat (7) @(posedge CLK);
        #1 RSTn = 1'b0;
        q.delete();
        @(posedge CLK);
        @(negedge CLK);
        check("mid_rst_valid", {31'd0, tx.o_tx_valid}, 0);
        check("mid_rst_data", {24'd0, tx.o_tx_data}, 0);
        check("mid_rst_busy", {31'd0, o_busy}, 0);
        check("mid_rst_ra", {27'd0, o_ra}, 0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        push_dump(4 * MDEPTH);
        start_dump();
        @(negedge CLK);
        check("restart_ra", {27'd0, o_ra}, 0);
        wait_done(5, "restart_done");

        // Sparse pattern: checksum byte is 0x01 when framing is on
        for (int i = 0; i < MDEPTH; i++) rf[i] = 32'h0;
        rf[3] = 32'h00000100;
        push_dump(4 * MDEPTH);
        x0 = xfer_cnt;
        start_dump();
        wait_done(6, "sparse_done");
        check("sparse_xfers", xfer_cnt - x0, 4 * MDEPTH + 2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
